// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path.
//   NUM_DIGITS / DP_DIGIT : digit count and position of the decimal point
//   SEG_BLANK             : all segments off (active-low)
//   SEG_TABLE / seg_decode: 4-bit digit -> {g,f,e,d,c,b,a} active-low pattern
//   conv_state_e          : serial binary-to-BCD converter states
package stopwatch_pkg;

    localparam int         NUM_DIGITS = 5;
    localparam int         DP_DIGIT   = 1;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    // Entry i holds the pattern for digit i; 10..15 can never come out of the
    // converter, so they decode as blank instead of hex glyphs.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-add-3, one input bit per cycle).
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : begin a conversion of num_i (honoured only in IDLE)
//   num_i      : binary value to convert
//   bcd_o      : last completed result, held until the next one finishes
//   valid_o    : one-cycle pulse in the cycle bcd_o takes a new value
//   busy_o     : high during the WIDTH shift cycles
//   state_o    : converter state, for observation
// Handshake: start_i is a request sampled only while state_o == IDLE; a
// request outside IDLE is simply not taken and must be re-presented.
module bin2bcd_serial
    import stopwatch_pkg::*;
#(
    parameter int WIDTH = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [WIDTH-1:0]        num_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    valid_o,
    output logic                    busy_o,
    output conv_state_e             state_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_e        state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   acc_shifted;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_shifted = {adj[BCD_W-2:0], shift_q[WIDTH-1]};
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        bitcnt_d = bitcnt_q;
        bcd_d    = bcd_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_d  = num_i;
                    acc_d    = '0;
                    bitcnt_d = '0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                acc_d    = acc_shifted;
                shift_d  = shift_q << 1;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == CNT_W'(WIDTH - 1)) begin
                    // Publish on the last shift so bcd and the pulse are
                    // both visible during the DONE cycle.
                    bcd_d   = acc_shifted;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            acc_q    <= '0;
            bitcnt_q <= '0;
            bcd_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            bitcnt_q <= bitcnt_d;
            bcd_q    <= bcd_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign state_o = state_q;

endmodule

// File: rtl/mostrador_7seg.sv
// Stopwatch display: converts the tenths-of-second count to BCD and scans it
// onto a 5-digit multiplexed seven-segment display shown as "XXXX.X".
//   clk, rst_n : clock, asynchronous active-low reset
//   num        : binary count in tenths of a second
//   seg, dp    : segment {g,f,e,d,c,b,a} and decimal point, active-low
//   an         : digit enables, active-low one-hot, an[0] = tenths
//   bcd        : latched BCD digits {d4..d0}
//   bcd_valid  : one-cycle pulse when bcd updates
//   busy       : conversion in progress
// Optional: define MOSTRADOR_BLANK_ZEROS_EN to blank leading zeros in d4..d2.
module mostrador_7seg
    import stopwatch_pkg::*;
#(
    parameter int WIDTH    = 15,
    parameter int SCAN_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        num,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    bcd_valid,
    output logic                    busy
);

    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    conv_state_e            conv_state;
    logic                   start;
    logic [WIDTH-1:0]       last_num_q, last_num_d;
    logic                   force_q, force_d;
    logic [SC_W-1:0]        scan_cnt_q, scan_cnt_d;
    logic [2:0]             scan_idx_q, scan_idx_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic [3:0]             digit;

    // A conversion is only requested when the converter can take it, so
    // last_num always records the value actually being converted.
    assign start = (conv_state == IDLE) && ((num != last_num_q) || force_q);

    bin2bcd_serial #(.WIDTH(WIDTH)) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .num_i   (num),
        .bcd_o   (bcd),
        .valid_o (bcd_valid),
        .busy_o  (busy),
        .state_o (conv_state)
    );

    always_comb begin
        last_num_d = last_num_q;
        force_d    = force_q;
        if (start) begin
            last_num_d = num;
            force_d    = 1'b0;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx_q + 3'd1;
        end
    end

    always_comb begin
        case (scan_idx_q)
            3'd0:    digit = bcd[3:0];
            3'd1:    digit = bcd[7:4];
            3'd2:    digit = bcd[11:8];
            3'd3:    digit = bcd[15:12];
            default: digit = bcd[19:16];
        endcase
        seg_d = seg_decode(digit);
`ifdef MOSTRADOR_BLANK_ZEROS_EN
        // Blank a digit when it and everything above it is zero; d1 and d0
        // always show so zero reads "0.0".
        if ((scan_idx_q >= 3'd2) && ((bcd >> {scan_idx_q, 2'b00}) == '0)) begin
            seg_d = SEG_BLANK;
        end
`endif
        an_d = ~(NUM_DIGITS'(1) << scan_idx_q);
        dp_d = (scan_idx_q != 3'(DP_DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_num_q <= '0;
            force_q    <= 1'b1;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            last_num_q <= last_num_d;
            force_q    <= force_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_mostrador_7seg.sv
// Directed bench for mostrador_7seg with a decimal-arithmetic reference model.
module tb_mostrador_7seg;

  localparam int WIDTH    = 15;
  localparam int SCAN_DIV = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [14:0] num   = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [4:0]  an;
  logic [19:0] bcd;
  logic        bcd_valid;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mostrador_7seg #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .num       (num),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int p10 [5] = '{1, 10, 100, 1000, 10000};

  int         m_k     = 0;   // edges since reset release
  int         m_cnt   = 0;   // cycles left until converter idle again
  bit         m_force = 1'b1;
  int         m_last  = 0;
  int         m_cap   = 0;
  int         m_val   = 0;   // value currently on the bcd output
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp  = 1'b1;
  logic [4:0] exp_an  = 5'h1F;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / p10[i]) % 10);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int idx;
    int d;
    if (!rst_n) begin
      m_k = 0; m_cnt = 0; m_force = 1'b1; m_last = 0; m_cap = 0; m_val = 0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 5'h1F;
    end else begin
      idx = (m_k / SCAN_DIV) % 5;
      d = (m_val / p10[idx]) % 10;
      exp_seg = pat[d];
`ifdef MOSTRADOR_BLANK_ZEROS_EN
      if (idx >= 2 && m_val < p10[idx]) exp_seg = 7'h7F;
`endif
      exp_an = ~(5'b00001 << idx);
      exp_dp = (idx != 1);
      m_k++;
      if (m_cnt == 0) begin
        if (int'(num) != m_last || m_force) begin
          m_last = int'(num); m_cap = int'(num); m_force = 1'b0; m_cnt = WIDTH + 1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 1) m_val = m_cap;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("seg", 32'(seg), 32'(exp_seg));
    check("dp", 32'(dp), 32'(exp_dp));
    check("an", 32'(an), 32'(exp_an));
    check("bcd", 32'(bcd), 32'(to_bcd(m_val)));
    check("bcd_valid", 32'(bcd_valid), 32'(m_cnt == 1));
    check("busy", 32'(busy), 32'(m_cnt >= 2));
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bcd_valid && cycles < 100);
    if (!bcd_valid) check({name, "_timeout"}, 32'(cycles), 32'd0);
  endtask

  task automatic wait_an(input logic [4:0] target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== target && n < 40);
    if (an !== target) check("wait_an_timeout", 32'(an), 32'(target));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
    check({tag, "_an"}, 32'(an), 32'h1F);
    check({tag, "_bcd"}, 32'(bcd), 32'h0);
    check({tag, "_valid"}, 32'(bcd_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int pulses;
    int bad;
    logic [19:0] seen [2];

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // num = 0 converted right after reset release
    wait_valid("first", cyc);
    check("first_latency", 32'(cyc), 32'd16);
    check("first_bcd", 32'(bcd), 32'h00000);
    repeat (24) @(negedge clk);

    // 10000: digit scan and decimal point placement
    num = 15'd10000;
    wait_valid("ten_k", cyc);
    check("ten_k_bcd", 32'(bcd), 32'h10000);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dp == 1'b0 && an != 5'b11101) bad++;
    end
    check("dp_only_units", 32'(bad), 32'd0);
    wait_an(5'b11101);
    check("dp_at_units", 32'(dp), 32'd0);

    // 12345: per-digit decode
    num = 15'd12345;
    wait_valid("mixed", cyc);
    check("mixed_bcd", 32'(bcd), 32'h12345);
    wait_an(5'b11110);
    check("seg_d0_5", 32'(seg), 32'h12);
    wait_an(5'b01111);
    check("seg_d4_1", 32'(seg), 32'h79);

    // maximum 15-bit input converts exactly
    num = 15'd32767;
    wait_valid("max", cyc);
    check("max_bcd", 32'(bcd), 32'h32767);
    repeat (4) @(negedge clk);

    // change during a conversion: both values get converted, in order
    num = 15'd100;
    repeat (5) @(negedge clk);
    num = 15'd200;
    pulses = 0;
    seen[0] = '0;
    seen[1] = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bcd_valid) begin
        if (pulses < 2) seen[pulses] = bcd;
        pulses++;
      end
    end
    check("two_pulses", 32'(pulses), 32'd2);
    check("pulse1_bcd", 32'(seen[0]), 32'h00100);
    check("pulse2_bcd", 32'(seen[1]), 32'h00200);

    // reset in the middle of a conversion
    num = 15'd777;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid("after_reset", cyc);
    check("after_reset_within_17", 32'(cyc <= 17), 32'd1);
    check("after_reset_bcd", 32'(bcd), 32'h00777);

`ifdef MOSTRADOR_BLANK_ZEROS_EN
    num = 15'd7;
    wait_valid("blank7", cyc);
    wait_an(5'b01111);
    check("blank7_d4", 32'(seg), 32'h7F);
    wait_an(5'b11011);
    check("blank7_d2", 32'(seg), 32'h7F);
    wait_an(5'b11101);
    check("blank7_d1", 32'(seg), 32'h40);
    check("blank7_dp", 32'(dp), 32'd0);
    wait_an(5'b11110);
    check("blank7_d0", 32'(seg), 32'h78);
    num = 15'd1005;
    wait_valid("blank1005", cyc);
    wait_an(5'b01111);
    check("blank1005_d4", 32'(seg), 32'h7F);
    wait_an(5'b10111);
    check("blank1005_d3", 32'(seg), 32'h79);
    wait_an(5'b11011);
    check("blank1005_d2", 32'(seg), 32'h40);
`else
    num = 15'd7;
    wait_valid("noblank7", cyc);
    wait_an(5'b01111);
    check("noblank7_d4", 32'(seg), 32'h40);
    wait_an(5'b11110);
    check("noblank7_d0", 32'(seg), 32'h78);
`endif

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
